// File: rtl/seg_pkg.sv
// Shared types, glyph encodings and sizing helpers for the seven-segment display controller.
package seg_pkg;

  // Which kind of image is currently committed to the display.
  typedef enum logic [1:0] {
    MODE_BLANK = 2'd0,
    MODE_HEX   = 2'd1,
    MODE_DEC   = 2'd2
  } mode_e;

  // Sequential binary-to-BCD converter states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Segment encoding is {dp,g,f,e,d,c,b,a}, active high; dp is never lit.
  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;

  // Number of BCD nibbles that always holds an unsigned DATA_W-bit value.
  function automatic int bcd_digits(input int data_w);
    return (data_w + 2) / 3;
  endfunction

  // Hex digit to segment pattern, 0-9 then A, b, C, d, E, F.
  function automatic logic [7:0] glyph(input logic [3:0] nibble);
    logic [7:0] g;
    case (nibble)
      4'h0: g = 8'h3F;
      4'h1: g = 8'h06;
      4'h2: g = 8'h5B;
      4'h3: g = 8'h4F;
      4'h4: g = 8'h66;
      4'h5: g = 8'h6D;
      4'h6: g = 8'h7D;
      4'h7: g = 8'h07;
      4'h8: g = 8'h7F;
      4'h9: g = 8'h6F;
      4'hA: g = 8'h77;
      4'hB: g = 8'h7C;
      4'hC: g = 8'h39;
      4'hD: g = 8'h5E;
      4'hE: g = 8'h79;
      default: g = 8'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one magnitude bit per cycle, sign kept aside.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic [DATA_W-1:0]               i_data,
  input  logic                            i_signed,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [4*bcd_digits(DATA_W)-1:0] o_bcd,
  output logic                            o_neg
);

  localparam int BCD_DIGITS = bcd_digits(DATA_W);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  conv_state_e       r_state;
  conv_state_e       w_state_next;
  logic [DATA_W-1:0] r_mag;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  w_bcd_adj;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg;
  logic              w_neg_load;
  logic [DATA_W-1:0] w_mag_load;

  assign w_neg_load = i_signed & i_data[DATA_W-1];
  // Two's complement negate; the most negative value maps onto its own bit pattern,
  // which read as unsigned is exactly its magnitude.
  assign w_mag_load = w_neg_load ? (~i_data + 1'b1) : i_data;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic; a new start restarts from any state, an abort wins over everything.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_CONV;
      ST_CONV:   if (r_cnt == LAST_CNT) w_state_next = ST_COMMIT;
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (i_start) w_state_next = ST_CONV;
    if (i_abort) w_state_next = ST_IDLE;
  end

  // Add-3 correction on every BCD nibble that would overflow after doubling.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // Load on start, otherwise shift one magnitude bit into the BCD register per CONV cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mag <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
    end else if (i_start) begin
      r_mag <= w_mag_load;
      r_bcd <= '0;
      r_cnt <= '0;
      r_neg <= w_neg_load;
    end else if (r_state == ST_CONV) begin
      r_mag <= r_mag << 1;
      r_bcd <= {w_bcd_adj[BCD_W-2:0], r_mag[DATA_W-1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  // A write landing in the commit cycle supersedes the finished result.
  assign o_done = (r_state == ST_COMMIT) & ~i_start & ~i_abort;
  assign o_bcd  = r_bcd;
  assign o_neg  = r_neg;

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped seven-segment controller: hex/decimal image, atomic commit, scanned banks.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int DATA_W   = 32,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seg_write,
  input  logic              seg_cs16,
  input  logic              seg_cs10,
  input  logic              dec_signed,
  input  logic [DATA_W-1:0] seg_data,
  output logic              busy,
  output logic [DIGITS-1:0] seg_en,
  output logic [7:0]        seg_out0,
  output logic [7:0]        seg_out1
);

  localparam int HALF       = DIGITS / 2;
  localparam int BCD_DIGITS = bcd_digits(DATA_W);
  localparam int PAD_DIGITS = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
  localparam int HEX_W      = 4 * DIGITS;
  localparam int DIV_W      = $clog2(SCAN_DIV);
  localparam int IDX_W      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF - 1);

  logic                      w_wr_hex;
  logic                      w_wr_dec;
  logic                      w_dec_done;
  logic [4*BCD_DIGITS-1:0]   w_bcd;
  logic [4*PAD_DIGITS-1:0]   w_bcd_pad;
  logic                      w_neg;
  logic [HEX_W-1:0]          w_hex_val;

  mode_e                     r_mode;
  mode_e                     w_mode_next;
  logic [DIGITS-1:0][7:0]    r_img;
  logic [DIGITS-1:0][7:0]    w_img_next;
  logic [DIGITS-1:0][7:0]    w_dec_img;

  logic [DIV_W-1:0]          r_div;
  logic [DIV_W-1:0]          w_div_next;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx_next;
  logic [DIGITS-1:0]         w_en_next;
  logic [7:0]                w_seg0_next;
  logic [7:0]                w_seg1_next;

  // Hex select wins when both selects are raised.
  assign w_wr_hex  = seg_write & seg_cs16;
  assign w_wr_dec  = seg_write & seg_cs10 & ~seg_cs16;
  assign w_hex_val = HEX_W'(seg_data);
  assign w_bcd_pad = (4*PAD_DIGITS)'(w_bcd);

  bin2bcd_seq #(
    .DATA_W (DATA_W)
  ) u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_wr_dec),
    .i_abort  (w_wr_hex),
    .i_data   (seg_data),
    .i_signed (dec_signed),
    .o_busy   (busy),
    .o_done   (w_dec_done),
    .o_bcd    (w_bcd),
    .o_neg    (w_neg)
  );

  // Decimal formatting: leading-zero blanking, sign left of the top digit, dashes on overflow.
  always_comb begin
    int n_sig;
    int n_total;
    n_sig = 1;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (w_bcd_pad[4*k +: 4] != 4'd0) n_sig = k + 1;
    end
    n_total = n_sig + (w_neg ? 1 : 0);
    for (int k = 0; k < DIGITS; k++) begin
      if (n_total > DIGITS)      w_dec_img[k] = GLYPH_DASH;
      else if (k < n_sig)        w_dec_img[k] = glyph(w_bcd_pad[4*k +: 4]);
      else if (w_neg && k == n_sig) w_dec_img[k] = GLYPH_DASH;
      else                       w_dec_img[k] = GLYPH_BLANK;
    end
  end

  // Image and mode commit together: hex immediately, decimal only when conversion finishes.
  always_comb begin
    w_mode_next = r_mode;
    w_img_next  = r_img;
    if (w_wr_hex) begin
      w_mode_next = MODE_HEX;
      for (int k = 0; k < DIGITS; k++) w_img_next[k] = glyph(w_hex_val[4*k +: 4]);
    end else if (w_dec_done) begin
      w_mode_next = MODE_DEC;
      w_img_next  = w_dec_img;
    end
  end

  // Scan divider and bank position; free running, untouched by commits.
  always_comb begin
    w_div_next = r_div + 1'b1;
    w_idx_next = r_idx;
    if (r_div == DIV_LAST) begin
      w_div_next = '0;
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Select the digit pair for the next scan position from the next image.
  always_comb begin
    w_en_next   = '0;
    w_seg0_next = GLYPH_BLANK;
    w_seg1_next = GLYPH_BLANK;
    for (int i = 0; i < HALF; i++) begin
      if (w_idx_next == IDX_W'(i)) begin
        w_en_next[i]        = 1'b1;
        w_en_next[i + HALF] = 1'b1;
        w_seg1_next         = w_img_next[i];
        w_seg0_next         = w_img_next[i + HALF];
      end
    end
  end

  // Display state and registered outputs; enables and segments always move together.
  // NOTE: the image array is reset too, so a blanked display never holds a stale image.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode   <= MODE_BLANK;
      r_img    <= '0;
      r_div    <= '0;
      r_idx    <= '0;
      seg_en   <= '0;
      seg_out0 <= '0;
      seg_out1 <= '0;
    end else begin
      r_mode <= w_mode_next;
      r_img  <= w_img_next;
      r_div  <= w_div_next;
      r_idx  <= w_idx_next;
      if (w_mode_next == MODE_BLANK) begin
        seg_en   <= '0;
        seg_out0 <= '0;
        seg_out1 <= '0;
      end else begin
        seg_en   <= w_en_next;
        seg_out0 <= w_seg0_next;
        seg_out1 <= w_seg1_next;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed plan plus randomized writes vs. a decimal model.
module tb_seg_display_ctrl;

  localparam int DIGITS   = 8;
  localparam int DATA_W   = 32;
  localparam int SCAN_DIV = 4;
  localparam int HALF     = DIGITS / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seg_write = 1'b0;
  logic        seg_cs16 = 1'b0;
  logic        seg_cs10 = 1'b0;
  logic        dec_signed = 1'b0;
  logic [31:0] seg_data = '0;
  logic        busy;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out0;
  logic [7:0]  seg_out1;

  int n_checks = 0;
  int n_errors = 0;
  int n_edges  = 0;

  logic [7:0] glyph_ref [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] exp_img [DIGITS];
  bit         exp_blank;

  seg_display_ctrl #(
    .DIGITS   (DIGITS),
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_write  (seg_write),
    .seg_cs16   (seg_cs16),
    .seg_cs10   (seg_cs10),
    .dec_signed (dec_signed),
    .seg_data   (seg_data),
    .busy       (busy),
    .seg_en     (seg_en),
    .seg_out0   (seg_out0),
    .seg_out1   (seg_out1)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was last released; the scan position follows from it.
  always @(posedge clk) n_edges <= rst ? n_edges + 1 : 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_display(input string tag);
    int idx;
    logic [7:0] e_en, e0, e1;
    idx = (n_edges / SCAN_DIV) % HALF;
    if (exp_blank) begin
      e_en = 8'h00; e0 = 8'h00; e1 = 8'h00;
    end else begin
      e_en = 8'((1 << idx) | (1 << (idx + HALF)));
      e0   = exp_img[idx + HALF];
      e1   = exp_img[idx];
    end
    check({tag, ".en"},   32'(seg_en),   32'(e_en));
    check({tag, ".out0"}, 32'(seg_out0), 32'(e0));
    check({tag, ".out1"}, 32'(seg_out1), 32'(e1));
  endtask

  function automatic void set_hex(input logic [31:0] d);
    exp_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) exp_img[k] = glyph_ref[(d >> (4*k)) & 32'hF];
  endfunction

  function automatic void set_dec(input logic [31:0] d, input bit sgn);
    longint v, mag;
    bit     neg;
    int     dig[$];
    v   = sgn ? longint'($signed(d)) : longint'(d);
    neg = (v < 0);
    mag = neg ? -v : v;
    dig.delete();
    do begin
      dig.push_back(int'(mag % 10));
      mag = mag / 10;
    end while (mag != 0);
    exp_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) exp_img[k] = 8'h00;
    if (dig.size() + (neg ? 1 : 0) > DIGITS) begin
      for (int k = 0; k < DIGITS; k++) exp_img[k] = 8'h40;
    end else begin
      for (int k = 0; k < dig.size(); k++) exp_img[k] = glyph_ref[dig[k]];
      if (neg) exp_img[dig.size()] = 8'h40;
    end
  endfunction

  // One write strobe; returns in cycle 1 with the bus idle and data scrambled.
  task automatic drive_write(input logic cs16, input logic cs10, input logic sgn,
                             input logic [31:0] d);
    seg_write  = 1'b1;
    seg_cs16   = cs16;
    seg_cs10   = cs10;
    dec_signed = sgn;
    seg_data   = d;
    tick();
    seg_write  = 1'b0;
    seg_cs16   = 1'b0;
    seg_cs10   = 1'b0;
    dec_signed = 1'b0;
    seg_data   = $urandom();
  endtask

  task automatic hex_write(input string tag, input logic [31:0] d);
    drive_write(1'b1, 1'b0, 1'b0, d);
    set_hex(d);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check_display(tag);
  endtask

  // Busy and the old image must hold for cycles 1..DATA_W+1; new image from DATA_W+2.
  task automatic dec_write(input string tag, input logic [31:0] d, input bit sgn);
    drive_write(1'b0, 1'b1, sgn, d);
    for (int c = 1; c <= DATA_W + 1; c++) begin
      check({tag, ".busy_conv"}, 32'(busy), 32'd1);
      check_display({tag, ".hold"});
      tick();
    end
    set_dec(d, sgn);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check_display({tag, ".commit"});
  endtask

  task automatic scan_all(input string tag);
    repeat (HALF * SCAN_DIV) begin
      tick();
      check_display(tag);
    end
  endtask

  initial begin
    for (int k = 0; k < DIGITS; k++) exp_img[k] = 8'h00;
    exp_blank = 1'b1;

    // Reset state.
    rst = 1'b0;
    repeat (3) tick();
    check("reset.busy", 32'(busy), 32'd0);
    check_display("reset");
    rst = 1'b1;
    repeat (3) begin
      tick();
      check_display("blank_idle");
    end
    check("blank.busy", 32'(busy), 32'd0);

    // Hex image and scan sequence.
    hex_write("hex_12abcd09", 32'h12AB_CD09);
    scan_all("hex_scan");

    // Decimal formatting cases.
    dec_write("dec_1234", 32'd1234, 1'b0);
    scan_all("dec_1234_scan");
    dec_write("dec_zero", 32'd0, 1'b0);
    scan_all("dec_zero_scan");
    dec_write("dec_neg5", 32'hFFFF_FFFB, 1'b1);
    scan_all("dec_neg5_scan");
    dec_write("dec_minint", 32'h8000_0000, 1'b1);
    scan_all("dec_minint_scan");
    dec_write("dec_99999999", 32'd99999999, 1'b0);
    scan_all("dec_99999999_scan");
    dec_write("dec_100000000", 32'd100000000, 1'b0);
    scan_all("dec_100000000_scan");
    dec_write("dec_neg1234567", -32'sd1234567, 1'b1);
    scan_all("dec_neg1234567_scan");
    dec_write("dec_neg12345678", -32'sd12345678, 1'b1);
    scan_all("dec_neg12345678_scan");

    // Restart: 777 at cycle 0, 42 at cycle 10; only 42 ever appears, at cycle 44.
    drive_write(1'b0, 1'b1, 1'b0, 32'd777);
    for (int c = 1; c <= 9; c++) begin
      check("restart.busy_a", 32'(busy), 32'd1);
      check_display("restart.hold_a");
      tick();
    end
    drive_write(1'b0, 1'b1, 1'b0, 32'd42);
    for (int c = 11; c <= 43; c++) begin
      check("restart.busy_b", 32'(busy), 32'd1);
      check_display("restart.hold_b");
      tick();
    end
    set_dec(32'd42, 1'b0);
    check("restart.busy_done", 32'(busy), 32'd0);
    check_display("restart.commit");
    scan_all("restart_scan");

    // Hex write aborts a conversion and commits at once.
    drive_write(1'b0, 1'b1, 1'b0, 32'd12345);
    for (int c = 1; c <= 4; c++) begin
      check("abort.busy", 32'(busy), 32'd1);
      tick();
    end
    hex_write("abort_hex", 32'h0000_CAFE);
    repeat (40) begin
      tick();
      check("abort.busy_after", 32'(busy), 32'd0);
      check_display("abort.no_late_commit");
    end

    // Synchronous reset at cycle 15 of a conversion.
    drive_write(1'b0, 1'b1, 1'b0, 32'd31337);
    for (int c = 1; c <= 14; c++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_blank = 1'b1;
    check("midreset.busy", 32'(busy), 32'd0);
    check_display("midreset");
    repeat (40) begin
      tick();
      check("midreset.busy_after", 32'(busy), 32'd0);
      check_display("midreset.no_commit");
    end

    // Both selects: hex wins, no conversion starts.
    hex_write("both_sel", 32'h0000_0010);
    scan_all("both_sel_scan");

    // Strobe without a select changes nothing.
    seg_write = 1'b1;
    seg_data  = 32'hFFFF_FFFF;
    tick();
    seg_write = 1'b0;
    check("nosel.busy", 32'(busy), 32'd0);
    check_display("nosel");
    scan_all("nosel_scan");

    // Randomized writes against the model.
    for (int i = 0; i < 10; i++) begin
      int unsigned kind, cls;
      logic [31:0] d;
      kind = $urandom_range(0, 2);
      cls  = $urandom_range(0, 3);
      case (cls)
        0:       d = 32'($urandom_range(0, 9));
        1:       d = 32'($urandom_range(0, 99999));
        2:       d = 32'($urandom_range(0, 99999999));
        default: d = $urandom();
      endcase
      if (kind == 2 && $urandom_range(0, 1) == 1) d = -d;
      if (kind == 0) hex_write("rand_hex", d);
      else           dec_write("rand_dec", d, kind == 2);
      scan_all("rand_scan");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
